// File: rtl/remote_comm_pkg.sv
// ---------------------------------------------------------------------------
// remote_comm_pkg
// Shared types and constants for the knight robot remote controller.
//   tx_state_t : byte sequencing states of the command transmitter
//   rx_state_t : states of the single-byte response receiver
//   DEFAULT_BAUD_DIV, FRAME_BITS, ACK_POS, ACK_MOVE : shared constants
//   frame_bit() : picks one bit of a start/data/stop UART frame
// ---------------------------------------------------------------------------
package remote_comm_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        BYTE_HI,
        BYTE_LO
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int         DEFAULT_BAUD_DIV = 2604;
    localparam int         FRAME_BITS       = 10;
    localparam logic [7:0] ACK_POS          = 8'hA5;
    localparam logic [7:0] ACK_MOVE         = 8'h5A;

    // Bit idx of the frame {stop, data[7:0], start}; idx 0 is the start bit.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        if (idx > 4'd9) begin
            return 1'b1;
        end
        return frame[idx];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive path for single-byte robot responses: input synchroniser, falling
// edge start detection, mid-bit sampling, stop-bit check and rdy handling.
// Build option: REMOTE_COMM_RX_SYNC_EN selects a two-flop synchroniser
// (otherwise a single flop); both reset to the idle level 1.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   rx    in   serial line, idle high
//   rdy   out  high while data holds a freshly received byte
//   data  out  last correctly framed byte
// ---------------------------------------------------------------------------
module uart_rx
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rdy,
    output logic [7:0] data
);

    localparam int         CNT_W   = 12;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);

    logic rx_s;
    logic rx_prev;

`ifdef REMOTE_COMM_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= rx;
        end
    end

    assign rx_s = sync_q;
`endif

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             rdy_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data    <= '0;
            rdy     <= 1'b0;
            rx_prev <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            data    <= data_n;
            rdy     <= rdy_n;
            rx_prev <= rx_s;
        end
    end

    // START waits half a bit to reach the start-bit centre; every later
    // sample is a full bit period after the previous one.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = data;
        rdy_n     = rdy;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                    rdy_n   = 1'b0;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    // A low stop bit is a framing error: drop the byte.
                    if (rx_s) begin
                        data_n = shift;
                        rdy_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/remote_comm.sv
// ---------------------------------------------------------------------------
// remote_comm
// Bench-side remote controller for the knight robot. Sends a 16-bit command
// as two UART bytes (high byte first) and presents single-byte responses.
// Build option: REMOTE_COMM_RX_SYNC_EN (two-flop RX synchroniser, handled
// inside uart_rx); transmit behaviour does not depend on it.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   RX       in   serial input from robot TX, idle high
//   TX       out  serial output to robot RX, idle high
//   cmd      in   16-bit command, captured when snd_cmd is accepted
//   snd_cmd  in   one-cycle send request, honoured only when idle
//   cmd_snt  out  high once both bytes are out, until the next accept
//   resp_rdy out  high while resp holds a newly received byte
//   resp     out  last received byte
// ---------------------------------------------------------------------------
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int               CNT_W   = 12;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (RX),
        .rdy  (resp_rdy),
        .data (resp)
    );

    tx_state_t        state, state_n;
    logic [15:0]      cmd_q, cmd_q_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic             tx_q, tx_n;
    logic             done_q, done_n;
    logic             snt_q, snt_n;
    logic [7:0]       cur_byte;

    assign cur_byte = (state == BYTE_HI) ? cmd_q[15:8] : cmd_q[7:0];
    assign TX       = tx_q;
    assign cmd_snt  = snt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cmd_q   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            snt_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cmd_q   <= cmd_q_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
            snt_q   <= snt_n;
        end
    end

    // TX is registered from the counters, so the line lags the sequencer by
    // one cycle. done_q carries that lag into cmd_snt and also blocks a new
    // accept in the cycle cmd_snt is raised.
    always_comb begin
        state_n   = state;
        cmd_q_n   = cmd_q;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        tx_n      = tx_q;
        done_n    = done_q;
        snt_n     = snt_q;
        case (state)
            TX_IDLE: begin
                tx_n = 1'b1;
                if (done_q) begin
                    snt_n  = 1'b1;
                    done_n = 1'b0;
                end else if (snd_cmd) begin
                    state_n   = BYTE_HI;
                    cmd_q_n   = cmd;
                    snt_n     = 1'b0;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                end
            end
            BYTE_HI, BYTE_LO: begin
                tx_n = frame_bit(cur_byte, bit_idx);
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_n = '0;
                        if (state == BYTE_HI) begin
                            state_n = BYTE_LO;
                        end else begin
                            state_n = TX_IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_remote_comm.sv
// ---------------------------------------------------------------------------
// tb_remote_comm
// Directed self-checking bench for remote_comm at BAUD_DIV=16.
// ---------------------------------------------------------------------------
module tb_remote_comm;

    localparam int B = 16;

`ifdef REMOTE_COMM_RX_SYNC_EN
    localparam int RX_EXTRA = 1;
`else
    localparam int RX_EXTRA = 0;
`endif

    // Cycles from the post-edge RX fall to resp_rdy becoming visible.
    localparam int RX_LAT = B / 2 + 9 * B + 2 + RX_EXTRA;
    localparam int SNT_T  = 20 * B + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [15:0] cmd = 16'h0000;
    logic        snd_cmd = 1'b0;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_rise = -1;
    logic rdy_prev = 1'b0;

    remote_comm #(
        .BAUD_DIV(B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .TX      (tx),
        .cmd     (cmd),
        .snd_cmd (snd_cmd),
        .cmd_snt (cmd_snt),
        .resp_rdy(resp_rdy),
        .resp    (resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the posedge count at which resp_rdy last went high.
    always @(negedge clk) begin
        if (resp_rdy === 1'b1 && rdy_prev === 1'b0) begin
            rdy_rise = cyc;
        end
        rdy_prev = resp_rdy;
    end

    // Sends snd_cmd with value, then samples TX at bit centres for two frames.
    task automatic tx_capture(input logic [15:0] value, input int extra_t,
                              input logic [15:0] late_cmd,
                              output logic [7:0] hi, output logic [7:0] lo,
                              output int snt_t, output logic framing_ok);
        int t;
        int pos;
        int b;
        cmd = value;
        snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        t = 0;
        hi = 8'h00;
        lo = 8'h00;
        snt_t = -1;
        framing_ok = 1'b1;
        repeat (330) begin
            snd_cmd = (t + 1 == extra_t);
            if (t == 50) cmd = late_cmd;
            @(posedge clk); #1;
            t++;
            if (cmd_snt === 1'b1 && snt_t < 0) snt_t = t;
            if (t >= B / 2 && t < 20 * B && ((t - B / 2) % B) == 0) begin
                pos = (t - B / 2) / B;
                b = pos % 10;
                if (b == 0) begin
                    if (tx !== 1'b0) framing_ok = 1'b0;
                end else if (b == 9) begin
                    if (tx !== 1'b1) framing_ok = 1'b0;
                end else if (pos < 10) begin
                    hi[b-1] = tx;
                end else begin
                    lo[b-1] = tx;
                end
            end
        end
        snd_cmd = 1'b0;
    endtask

    // Drives one UART frame on RX, starting right after the current edge.
    task automatic rx_drive(input logic [7:0] val, input logic stop_bit, output int start_cyc);
        logic [9:0] fr;
        fr = {stop_bit, val, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (B) begin
                @(posedge clk); #1;
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            total++;
            if ({tx, cmd_snt, resp_rdy, resp} !== 11'b100_0000_0000) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d: got tx=%b snt=%b rdy=%b resp=%h, want 1 0 0 00",
                         i, tx, cmd_snt, resp_rdy, resp);
            end
        end
    endtask

    task automatic test_tx_basic;
        logic [7:0] hi, lo;
        int snt_t;
        logic fok;
        tx_capture(16'h7020, 100, 16'hFFFF, hi, lo, snt_t, fok);
        total++;
        if (hi !== 8'h70) begin
            bad++; $display("[TB] FAIL tx_hi: got %h want 70", hi);
        end
        total++;
        if (lo !== 8'h20) begin
            bad++; $display("[TB] FAIL tx_lo: got %h want 20", lo);
        end
        total++;
        if (fok !== 1'b1) begin
            bad++; $display("[TB] FAIL tx_framing: got %b want 1", fok);
        end
        total++;
        if (snt_t !== SNT_T) begin
            bad++; $display("[TB] FAIL tx_snt_edge: got %0d want %0d", snt_t, SNT_T);
        end
        total++;
        if ({tx, cmd_snt} !== 2'b11) begin
            bad++; $display("[TB] FAIL tx_idle_after: got tx=%b snt=%b want 1 1", tx, cmd_snt);
        end
    endtask

    task automatic test_rx_ack;
        int n1, n2;
        rx_drive(8'hA5, 1'b1, n1);
        total++;
        if ({resp_rdy, resp} !== 9'h1A5) begin
            bad++; $display("[TB] FAIL rx_a5: got rdy=%b resp=%h want 1 a5", resp_rdy, resp);
        end
        total++;
        if (rdy_rise !== n1 + RX_LAT) begin
            bad++; $display("[TB] FAIL rx_a5_latency: got %0d want %0d", rdy_rise, n1 + RX_LAT);
        end
        fork
            rx_drive(8'h5A, 1'b1, n2);
            begin
                repeat (B / 2) begin
                    @(posedge clk); #1;
                end
                total++;
                if (resp_rdy !== 1'b0) begin
                    bad++; $display("[TB] FAIL rx_rdy_clear: got %b want 0", resp_rdy);
                end
            end
        join
        total++;
        if ({resp_rdy, resp} !== 9'h15A) begin
            bad++; $display("[TB] FAIL rx_5a: got rdy=%b resp=%h want 1 5a", resp_rdy, resp);
        end
        total++;
        if (rdy_rise !== n2 + RX_LAT) begin
            bad++; $display("[TB] FAIL rx_5a_latency: got %0d want %0d", rdy_rise, n2 + RX_LAT);
        end
    endtask

    task automatic test_rx_errors;
        int n;
        rx_drive(8'h3C, 1'b0, n);
        repeat (B) begin
            @(posedge clk); #1;
        end
        total++;
        if ({resp_rdy, resp} !== 9'h05A) begin
            bad++; $display("[TB] FAIL rx_framing: got rdy=%b resp=%h want 0 5a", resp_rdy, resp);
        end
        rx = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rx = 1'b1;
        repeat (12 * B) begin
            @(posedge clk); #1;
        end
        total++;
        if ({resp_rdy, resp} !== 9'h05A) begin
            bad++; $display("[TB] FAIL rx_glitch: got rdy=%b resp=%h want 0 5a", resp_rdy, resp);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] hi, lo;
        int snt_t;
        logic fok;
        cmd = 16'h1234;
        snd_cmd = 1'b1;
        @(posedge clk); #1;
        snd_cmd = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        total++;
        if (tx !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_tx_before_reset: got %b want 0", tx);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({tx, cmd_snt, resp_rdy, resp} !== 11'b100_0000_0000) begin
            bad++; $display("[TB] FAIL mid_reset: got tx=%b snt=%b rdy=%b resp=%h want 1 0 0 00",
                            tx, cmd_snt, resp_rdy, resp);
        end
        tx_capture(16'h1234, -1, 16'h1234, hi, lo, snt_t, fok);
        total++;
        if ({hi, lo} !== 16'h1234 || fok !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_resend: got %h%h framing=%b want 1234 1", hi, lo, fok);
        end
        total++;
        if (snt_t !== SNT_T) begin
            bad++; $display("[TB] FAIL mid_resend_snt: got %0d want %0d", snt_t, SNT_T);
        end
    endtask

    task automatic test_overlap;
        logic [7:0] hi, lo;
        int snt_t;
        logic fok;
        int n;
        fork
            tx_capture(16'hFFFF, -1, 16'hFFFF, hi, lo, snt_t, fok);
            begin
                repeat (20) begin
                    @(posedge clk); #1;
                end
                rx_drive(8'h5A, 1'b1, n);
            end
        join
        total++;
        if ({hi, lo} !== 16'hFFFF || fok !== 1'b1 || snt_t !== SNT_T) begin
            bad++; $display("[TB] FAIL overlap_tx: got %h%h framing=%b snt=%0d want ffff 1 %0d",
                            hi, lo, fok, snt_t, SNT_T);
        end
        total++;
        if ({resp_rdy, resp} !== 9'h15A) begin
            bad++; $display("[TB] FAIL overlap_rx: got rdy=%b resp=%h want 1 5a", resp_rdy, resp);
        end
        total++;
        if (rdy_rise !== n + RX_LAT) begin
            bad++; $display("[TB] FAIL overlap_latency: got %0d want %0d", rdy_rise, n + RX_LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] hi, lo;
        int snt_t;
        logic fok;
        int waited;
        tx_capture(16'hA55A, SNT_T, 16'hA55A, hi, lo, snt_t, fok);
        total++;
        if ({tx, cmd_snt} !== 2'b11 || snt_t !== SNT_T) begin
            bad++; $display("[TB] FAIL b2b_same_cycle_ignored: got tx=%b snt=%b edge=%0d want 1 1 %0d",
                            tx, cmd_snt, snt_t, SNT_T);
        end
        tx_capture(16'h0F0F, SNT_T + 1, 16'h0F0F, hi, lo, snt_t, fok);
        total++;
        if ({tx, cmd_snt} !== 2'b00) begin
            bad++; $display("[TB] FAIL b2b_next_cycle_accepted: got tx=%b snt=%b want 0 0", tx, cmd_snt);
        end
        waited = 0;
        while (cmd_snt !== 1'b1 && waited < 25 * B) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (cmd_snt !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_second_done: got snt=%b want 1 within %0d cycles", cmd_snt, 25 * B);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_ack();
        test_rx_errors();
        test_reset_mid();
        test_overlap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
